// File: rtl/inst_seq_player.sv
// Replays a length-prefixed instruction program from a sync-read RAM into the calculator core,
// strobing each instruction and waiting for its execute acknowledge under a timeout.
module inst_seq_player #(
  parameter int INST_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int SETUP_CYC   = 4,
  parameter int HOLD_CYC    = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              step_mode,
  input  logic              step,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [INST_W-1:0] rd_data,
  output logic [INST_W-1:0] inst,
  output logic              inst_stb,
  input  logic              exec_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] exec_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_LEN, S_LEN_WAIT, S_FETCH, S_FETCH_WAIT,
    S_SETUP, S_STROBE, S_ACK_WAIT, S_PAUSE, S_DONE, S_ERR
  } state_t;

  localparam int LW   = ADDR_W + 1;
  localparam int EW   = (INST_W > LW) ? INST_W : LW;
  localparam int M1   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAXC = (M1 > TIMEOUT_CYC) ? M1 : TIMEOUT_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [LW-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            ack_seen;
  logic            step_lat;
  logic [LW-1:0]   len;
  logic [LW-1:0]   pc_r;
  logic [LW-1:0]   pc_inc;
  logic [EW-1:0]   len_raw;
  logic [LW-1:0]   len_sat;
  logic            idle_like;
  logic            last_setup, last_hold, last_wait;
  logic            complete, timeout_hit;
  state_t          after_inst;

  // Length word needs one extra bit so a full-depth program (L = 2^ADDR_W) is representable.
  assign len_raw    = EW'(rd_data);
  assign len_sat    = (len_raw > EW'(LEN_MAX)) ? LEN_MAX : len_raw[LW-1:0];
  assign pc_inc     = pc_r + LW'(1);
  assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign last_setup = (cnt == CW'(SETUP_CYC - 1));
  assign last_hold  = (cnt == CW'(HOLD_CYC - 1));
  assign last_wait  = (cnt == CW'(TIMEOUT_CYC - 1));

  // An ack on the final ACK_WAIT cycle still completes the instruction rather than timing out.
  assign complete    = !abort &&
                       (((state == S_STROBE) && last_hold && (ack_seen || exec_ack)) ||
                        ((state == S_ACK_WAIT) && exec_ack));
  assign timeout_hit = !abort && (state == S_ACK_WAIT) && !exec_ack && last_wait;
  assign after_inst  = (pc_inc == len) ? S_DONE : (step_lat ? S_PAUSE : S_FETCH);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_FETCH_LEN;
      S_FETCH_LEN:  state_nxt = S_LEN_WAIT;
      S_LEN_WAIT:   state_nxt = (len_sat <= LW'(1)) ? S_DONE : S_FETCH;
      S_FETCH:      state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: state_nxt = S_SETUP;
      S_SETUP:      if (last_setup) state_nxt = S_STROBE;
      S_STROBE:     if (last_hold) state_nxt = (ack_seen || exec_ack) ? after_inst : S_ACK_WAIT;
      S_ACK_WAIT: begin
        if (exec_ack)       state_nxt = after_inst;
        else if (last_wait) state_nxt = S_ERR;
      end
      S_PAUSE:      if (step) state_nxt = S_FETCH;
      default:      state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_comb begin
    rd_en    = 1'b0;
    rd_addr  = '0;
    inst_stb = 1'b0;
    busy     = !idle_like;
    case (state)
      S_FETCH_LEN: rd_en = 1'b1;
      S_FETCH: begin
        rd_en   = 1'b1;
        rd_addr = pc_r[ADDR_W-1:0];
      end
      S_STROBE:    inst_stb = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      ack_seen <= 1'b0;
      step_lat <= 1'b0;
      len      <= '0;
      pc_r     <= '0;
      inst     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      exec_cnt <= '0;
    end else begin
      // Dwell counter restarts on every state change so each timed state counts from zero.
      if (state_nxt != state) cnt <= '0;
      else if ((state == S_SETUP) || (state == S_STROBE) || (state == S_ACK_WAIT)) cnt <= cnt + CW'(1);
      ack_seen <= (state == S_STROBE) && state_nxt == S_STROBE && (ack_seen || exec_ack);
      if (abort) begin
        done <= 1'b0;
        err  <= 1'b0;
      end else begin
        if (idle_like && start) begin
          done     <= 1'b0;
          err      <= 1'b0;
          exec_cnt <= '0;
          step_lat <= step_mode;
        end
        if (state == S_LEN_WAIT) begin
          len <= len_sat;
          if (len_sat <= LW'(1)) done <= 1'b1;
          else                   pc_r <= LW'(1);
        end
        if (state == S_FETCH_WAIT) inst <= rd_data;
        if (complete) begin
          exec_cnt <= exec_cnt + ADDR_W'(1);
          pc_r     <= pc_inc;
          if (pc_inc == len) done <= 1'b1;
        end
        if (timeout_hit) err <= 1'b1;
      end
    end
  end

  assign pc = pc_r[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_seq_player.sv
// Directed bench for inst_seq_player: RAM + core ack model, strobe monitor, expected-instruction queue.
module tb_inst_seq_player;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] inst;
  logic       inst_stb;
  logic       exec_ack = 1'b0;
  logic       busy, done, err;
  logic [9:0] pc, exec_cnt;

  inst_seq_player #(
    .INST_W(8), .ADDR_W(10), .SETUP_CYC(4), .HOLD_CYC(3), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step_mode(step_mode), .step(step),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .inst(inst), .inst_stb(inst_stb),
    .exec_ack(exec_ack), .busy(busy), .done(done), .err(err), .pc(pc), .exec_cnt(exec_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Strobe monitor and core ack model share one process so their counters have a single writer.
  int         run_id = 0, seen_run = 0;
  int         stb_cnt = 0, ack_pend = 0, fall_cyc = 0;
  int         nack_num = 0;
  logic       triple = 1'b0;
  logic       stb_prev = 1'b0;
  logic [7:0] obs_inst [16];
  int         rise_cyc [16];
  logic [9:0] rise_pc  [16];

  always @(negedge clk) begin
    if (run_id != seen_run) begin
      seen_run = run_id;
      stb_cnt  = 0;
    end
    exec_ack = 1'b0;
    if (ack_pend > 0) begin
      exec_ack = 1'b1;
      ack_pend--;
    end
    if (rst) begin
      stb_prev = 1'b0;
      ack_pend = 0;
    end else begin
      if (inst_stb && !stb_prev) begin
        if (stb_cnt < 16) begin
          obs_inst[stb_cnt] = inst;
          rise_cyc[stb_cnt] = cyc;
          rise_pc[stb_cnt]  = pc;
        end
        stb_cnt++;
        if (stb_cnt != nack_num) begin
          if (triple) begin
            exec_ack = 1'b1;
            ack_pend = 2;
          end else begin
            ack_pend = 1;
          end
        end
      end
      if (!inst_stb && stb_prev) fall_cyc = cyc;
      stb_prev = inst_stb;
    end
  end

  int         vectors = 0, miscompares = 0;
  int         start_cyc = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic sm);
    run_id++;
    step_mode = sm;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start     = 1'b0;
    step_mode = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check("done_wait", done, 1);
  endtask

  task automatic wait_strobes(input int target, input int bound);
    int n = 0;
    while (stb_cnt < target && n < bound) begin
      tick();
      n++;
    end
    check("strobe_wait", stb_cnt, target);
  endtask

  task automatic score();
    int n = exp_q.size();
    check("strobe_count", stb_cnt, n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (k < stb_cnt) check("inst", obs_inst[k], e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_stb"}, inst_stb, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_inst"}, inst, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_exec_cnt"}, exec_cnt, 0);
  endtask

  task automatic push_prog(input int n);
    logic [7:0] prog [3];
    prog = '{8'h05, 8'h41, 8'hC0};
    for (int k = 0; k < n; k++) exp_q.push_back(prog[k]);
  endtask

  initial begin
    int n;
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    mem[0] = 8'd4; mem[1] = 8'h05; mem[2] = 8'h41; mem[3] = 8'hC0;

    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Free run
    push_prog(3);
    start_run(1'b0);
    wait_done(100);
    check("free_first_rise", rise_cyc[0] - start_cyc, 9);
    check("free_rise_spacing", rise_cyc[1] - rise_cyc[0], 9);
    check("free_exec_cnt", exec_cnt, 3);
    check("free_pc", pc, 4);
    check("free_busy", busy, 0);
    score();

    // Empty programs: length 1 then length 0
    for (int L = 1; L >= 0; L--) begin
      mem[0] = 8'(L);
      start_run(1'b0);
      check("empty_done_cleared", done, 0);
      tick();
      tick();
      check("empty_done_c3", done, 1);
      check("empty_exec_cnt", exec_cnt, 0);
      check("empty_busy", busy, 0);
      repeat (10) tick();
      score();
    end
    mem[0] = 8'd4;

    // Timeout on second instruction
    nack_num = 2;
    push_prog(2);
    start_run(1'b0);
    n = 0;
    while (!err && n < 200) begin
      tick();
      n++;
    end
    check("timeout_err", err, 1);
    check("timeout_delay", cyc - fall_cyc, 20);
    check("timeout_pc", pc, 2);
    check("timeout_exec_cnt", exec_cnt, 1);
    check("timeout_busy", busy, 0);
    repeat (30) tick();
    check("timeout_err_held", err, 1);
    score();
    nack_num = 0;

    // Step mode
    push_prog(3);
    start_run(1'b1);
    repeat (70) tick();
    check("step_stb1", stb_cnt, 1);
    check("step_busy1", busy, 1);
    step = 1'b1; tick(); step = 1'b0;
    repeat (30) tick();
    check("step_stb2", stb_cnt, 2);
    check("step_busy2", busy, 1);
    check("step_done2", done, 0);
    step = 1'b1; tick(); step = 1'b0;
    repeat (30) tick();
    check("step_done3", done, 1);
    check("step_exec_cnt", exec_cnt, 3);
    score();

    // Abort during the second cycle of the second strobe
    push_prog(2);
    start_run(1'b0);
    wait_strobes(2, 100);
    check("abort_stb_high", inst_stb, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_stb", inst_stb, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_pc_held", pc, 2);
    check("abort_exec_cnt_held", exec_cnt, 1);
    check("abort_inst_held", inst, 8'h41);
    repeat (10) tick();
    score();

    push_prog(3);
    start_run(1'b0);
    wait_done(100);
    check("restart_pc1", rise_pc[0], 1);
    check("restart_exec_cnt", exec_cnt, 3);
    score();

    // Reset in SETUP of the first instruction
    start_run(1'b0);
    repeat (5) tick();
    rst = 1'b1; tick();
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (10) tick();
    score();

    // Three acks inside each strobe count once
    triple = 1'b1;
    push_prog(3);
    start_run(1'b0);
    wait_done(100);
    check("triple_exec_cnt", exec_cnt, 3);
    check("triple_pc", pc, 4);
    score();
    triple = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
